// File: rtl/serdes_rx_pkg.sv
// Shared types for the receive-side word aligner of the 4-bit DDR SERDES test link.
package serdes_rx_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } state_t;

    localparam logic [3:0] TRAIN_WORD_DEFAULT = 4'b1100;

endpackage

// File: rtl/serdes_rx_word_aligner.sv
// Word aligner behind an I_SERDES: pulses bitslip until the training word is seen
// LOCK_COUNT times in a row, then forwards payload words with a one-cycle latency.
module serdes_rx_word_aligner
    import serdes_rx_pkg::*;
#(
    parameter int                WIDTH      = 4,
    parameter logic [WIDTH-1:0]  TRAIN_WORD = TRAIN_WORD_DEFAULT,
    parameter int                LOCK_COUNT = 8,
    parameter int                SLIP_WAIT  = 3,
    parameter int                MAX_SLIPS  = 2 * WIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WIDTH-1:0]                 rx_word,
    input  logic                             rx_valid,
    input  logic                             realign,
    output logic                             bitslip,
    output logic [WIDTH-1:0]                 data_out,
    output logic                             data_valid,
    output logic                             aligned,
    output logic                             align_error,
    output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count
);

    localparam int SCW = $clog2(MAX_SLIPS + 1);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int WCW = $clog2(SLIP_WAIT + 1);

    localparam logic [MCW-1:0] LOCK_LAST = MCW'(LOCK_COUNT - 1);
    localparam logic [SCW-1:0] SLIP_MAX  = SCW'(MAX_SLIPS);
    localparam logic [WCW-1:0] WAIT_INIT = WCW'(SLIP_WAIT);

    state_t              state;
    logic [MCW-1:0]      match_cnt;
    logic [WCW-1:0]      wait_cnt;
    logic [WIDTH-1:0]    data_p1;
    logic                vld_p1;

    function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
        return (v == SLIP_MAX) ? v : v + SCW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            match_cnt   <= '0;
            wait_cnt    <= '0;
            bitslip     <= 1'b0;
            aligned     <= 1'b0;
            align_error <= 1'b0;
            slip_count  <= '0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
        end else if (realign) begin
            // Restart the hunt; a slip pulse in flight is dropped, payload word discarded.
            state       <= HUNT;
            match_cnt   <= '0;
            wait_cnt    <= '0;
            bitslip     <= 1'b0;
            aligned     <= 1'b0;
            align_error <= 1'b0;
            slip_count  <= '0;
            vld_p1      <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            vld_p1  <= 1'b0;
            case (state)
                HUNT: begin
                    if (rx_valid) begin
                        if (rx_word == TRAIN_WORD) begin
                            if (match_cnt == LOCK_LAST) begin
                                state     <= LOCKED;
                                aligned   <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MCW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                            if (slip_count == SLIP_MAX) begin
                                state       <= FAIL;
                                align_error <= 1'b1;
                            end else begin
                                state      <= SLIP;
                                bitslip    <= 1'b1;
                                slip_count <= sat_inc(slip_count);
                            end
                        end
                    end
                end
                SLIP: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                WAIT: begin
                    // I_SERDES output is unsettled right after a slip; ignore it.
                    if (wait_cnt == WCW'(1)) begin
                        state    <= HUNT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                LOCKED: begin
                    // p1: payload register stage
                    vld_p1 <= rx_valid;
                    if (rx_valid) begin
                        data_p1 <= rx_word;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

    assign data_out   = data_p1;
    assign data_valid = vld_p1;

endmodule

// File: tb/tb_serdes_rx_word_aligner.sv
// Bench for serdes_rx_word_aligner: vector table, directed corner sequences and
// randomized traffic through a rotating-channel model, all scored against a reference model.
module tb_serdes_rx_word_aligner;

    localparam int         WIDTH      = 4;
    localparam logic [3:0] TRAIN      = 4'b1100;
    localparam int         LOCK_COUNT = 8;
    localparam int         SLIP_WAIT  = 3;
    localparam int         MAX_SLIPS  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       realign = 1'b0;
    logic       rx_valid = 1'b0;
    logic [3:0] rx_word = 4'h0;
    logic       bitslip;
    logic [3:0] data_out;
    logic       data_valid;
    logic       aligned;
    logic       align_error;
    logic [3:0] slip_count;

    always #5 clock = ~clock;

    serdes_rx_word_aligner #(
        .WIDTH      (WIDTH),
        .TRAIN_WORD (TRAIN),
        .LOCK_COUNT (LOCK_COUNT),
        .SLIP_WAIT  (SLIP_WAIT),
        .MAX_SLIPS  (MAX_SLIPS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_word     (rx_word),
        .rx_valid    (rx_valid),
        .realign     (realign),
        .bitslip     (bitslip),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .aligned     (aligned),
        .align_error (align_error),
        .slip_count  (slip_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int phase = 0;
    int pulses = 0;
    int last_pulse = -1000;
    int min_gap = 1000;
    logic prev_bs = 1'b0;

    // Reference model: lock flag, fail flag, blind-cycle countdown, run length of matches.
    bit         m_locked, m_failed;
    int         m_blind, m_run, m_slips;
    logic       e_bs, e_dv;
    logic [3:0] e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] rotr(input logic [3:0] w, input int k);
        logic [3:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[0], r[3:1]};
        return r;
    endfunction

    task automatic model_step(input logic r, input logic ra, input logic v, input logic [3:0] w);
        e_bs = 1'b0;
        if (r) begin
            m_locked = 0; m_failed = 0; m_blind = 0; m_run = 0; m_slips = 0;
            e_dv = 1'b0; e_data = 4'h0;
        end else if (ra) begin
            m_locked = 0; m_failed = 0; m_blind = 0; m_run = 0; m_slips = 0;
            e_dv = 1'b0;
        end else begin
            e_dv = 1'b0;
            if (m_locked) begin
                e_dv = v;
                if (v) e_data = w;
            end else if (m_failed) begin
                // stays failed
            end else if (m_blind > 0) begin
                m_blind--;
            end else if (v) begin
                if (w == TRAIN) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_locked = 1;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                    if (m_slips == MAX_SLIPS) begin
                        m_failed = 1;
                    end else begin
                        m_slips++;
                        e_bs = 1'b1;
                        m_blind = SLIP_WAIT + 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic ra, input logic v, input logic [3:0] w);
        reset = r; realign = ra; rx_valid = v; rx_word = w;
        model_step(r, ra, v, w);
        @(posedge clock);
        #1;
        cyc++;
        check("bitslip", bitslip, e_bs);
        check("data_valid", data_valid, e_dv);
        check("data_out", data_out, e_data);
        check("aligned", aligned, m_locked);
        check("align_error", align_error, m_failed);
        check("slip_count", slip_count, m_slips);
        check("bitslip_back_to_back", bitslip & prev_bs, 1'b0);
        if (bitslip) begin
            pulses++;
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
            phase = (phase + 1) % WIDTH;
        end
        prev_bs = bitslip;
    endtask

    task automatic chan(input logic v, input logic [3:0] w);
        step(1'b0, 1'b0, v, rotr(w, phase));
    endtask

    task automatic clear_stats();
        pulses = 0; last_pulse = -1000; min_gap = 1000;
    endtask

    typedef struct {
        logic rst, ra, v;
        logic [3:0] w;
        logic bs, dv, al, er;
        logic [3:0] sc, d;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got timeout, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0};
        for (int i = 1; i <= 7; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, TRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, TRAIN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'h5,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'h5};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'hA,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'hA};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'h3,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'hA};

        // Vector table: reset, straight lock, payload with one-cycle latency.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].ra, tbl[i].v, tbl[i].w);
            check($sformatf("vec%0d_bitslip", i), bitslip, tbl[i].bs);
            check($sformatf("vec%0d_data_valid", i), data_valid, tbl[i].dv);
            check($sformatf("vec%0d_aligned", i), aligned, tbl[i].al);
            check($sformatf("vec%0d_align_error", i), align_error, tbl[i].er);
            check($sformatf("vec%0d_slip_count", i), slip_count, tbl[i].sc);
            check($sformatf("vec%0d_data_out", i), data_out, tbl[i].d);
        end

        // Stream rotated by one bit: three slips to reach the boundary.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        phase = 1; clear_stats();
        for (int i = 0; i < 200 && !aligned; i++) chan(1'b1, TRAIN);
        check("rot_aligned", aligned, 1'b1);
        check("rot_slip_count", slip_count, 3);
        check("rot_pulses", pulses, 3);
        check("rot_gap_ok", min_gap >= SLIP_WAIT + 1, 1'b1);

        // Never-matching input: exhaust slips, then silent failure.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        phase = 0; clear_stats();
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
        check("fail_error", align_error, 1'b1);
        check("fail_aligned", aligned, 1'b0);
        check("fail_slip_count", slip_count, MAX_SLIPS);
        check("fail_pulses", pulses, MAX_SLIPS);
        clear_stats();
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 4'($urandom));
        check("fail_quiet_pulses", pulses, 0);
        check("fail_sticky", align_error, 1'b1);

        // Seven matches, one mismatch, then a fresh run of eight.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        clear_stats();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, TRAIN);
        step(1'b0, 1'b0, 1'b1, 4'b0101);
        for (int i = 0; i < SLIP_WAIT + 1; i++) step(1'b0, 1'b0, 1'b1, TRAIN);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, TRAIN);
        check("run2_not_yet", aligned, 1'b0);
        step(1'b0, 1'b0, 1'b1, TRAIN);
        check("run2_aligned", aligned, 1'b1);
        check("run2_pulses", pulses, 1);
        check("run2_slip_count", slip_count, 1);

        // Valid gaps while hunting and while locked.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, TRAIN);
            if (i < 7) step(1'b0, 1'b0, 1'b0, 4'h0);
        end
        check("gap_aligned", aligned, 1'b1);
        check("gap_slip_count", slip_count, 0);
        for (int i = 0; i < 20; i++) begin
            logic v;
            v = 1'($urandom);
            step(1'b0, 1'b0, v, 4'($urandom));
            check("gap_dv_mirror", data_valid, v);
        end
        step(1'b0, 1'b0, 1'b1, 4'h3);
        check("gap_data3", data_out, 4'h3);
        step(1'b0, 1'b0, 1'b0, 4'h9);
        check("gap_hold_dv", data_valid, 1'b0);
        check("gap_hold_data", data_out, 4'h3);

        // Realign alongside a payload word, relock, realign mid-slip, reset mid-wait.
        step(1'b0, 1'b1, 1'b1, 4'h7);
        check("ra_dv", data_valid, 1'b0);
        check("ra_aligned", aligned, 1'b0);
        check("ra_data_held", data_out, 4'h3);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, TRAIN);
        check("ra_relock", aligned, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 4'h0);
        check("ra_slip_pulse", bitslip, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'h0);
        check("ra_slip_cut", bitslip, 1'b0);
        check("ra_slip_cleared", slip_count, 0);
        step(1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        check("rst_wait_outputs", {bitslip, data_valid, aligned, align_error, slip_count, data_out}, '0);

        // Randomized traffic through the rotating channel.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        phase = int'($urandom_range(0, WIDTH - 1));
        for (int i = 0; i < 3000; i++) begin
            logic r, ra, v;
            logic [3:0] w;
            r  = ($urandom_range(0, 999) == 0);
            ra = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 9) < 7) ? rotr(TRAIN, phase) : 4'($urandom);
            step(r, ra, v, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
